// File: rtl/lfsr_param.sv
// Parametrised Fibonacci LFSR with seed load, lockup handling and period measurement.
// The state register, wrap pulse, step counter and latched period all update on the same edge.
module lfsr_param #(
    parameter int               WIDTH        = 22,
    parameter logic [WIDTH-1:0] TAPS         = 22'h300000,
    parameter bit               USE_XNOR     = 1'b1,
    parameter logic [WIDTH-1:0] SEED         = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit               AUTO_RECOVER = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_data,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_period,
    output logic             o_locked
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    // XNOR feedback sticks at all-ones, XOR feedback sticks at all-zeros.
    localparam logic [WIDTH-1:0] LOCKUP = USE_XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam state_t           RST_STATE = (SEED == LOCKUP) ? S_LOCK : S_IDLE;

    function automatic logic parity_fn(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] data_r, data_nxt_s;
    logic [WIDTH-1:0] start_r, start_nxt_s;
    logic [WIDTH-1:0] count_r, count_nxt_s;
    logic [WIDTH-1:0] period_r, period_nxt_s;
    logic             wrap_r, wrap_nxt_s;
    logic             locked_r;
    logic             fb_s;
    logic [WIDTH-1:0] step_s;

    assign fb_s   = parity_fn(data_r & TAPS) ^ USE_XNOR;
    assign step_s = {data_r[WIDTH-2:0], fb_s};

    // Next-state, counter and period decisions in priority order load > enable > hold.
    always_comb begin
        data_nxt_s   = data_r;
        start_nxt_s  = start_r;
        count_nxt_s  = count_r;
        period_nxt_s = period_r;
        wrap_nxt_s   = 1'b0;
        state_nxt_s  = state_r;
        if (i_load) begin
            data_nxt_s  = i_seed;
            start_nxt_s = i_seed;
            count_nxt_s = ZERO;
            if (i_seed == LOCKUP) begin
                state_nxt_s = S_LOCK;
            end else begin
                state_nxt_s = S_IDLE;
            end
        end else if (i_enable) begin
            case (state_r)
                S_LOCK: begin
                    if (AUTO_RECOVER) begin
                        data_nxt_s  = SEED;
                        start_nxt_s = SEED;
                        count_nxt_s = ZERO;
                        state_nxt_s = RST_STATE;
                    end else begin
                        // Lockup is a fixed point: the step is counted but the state stays.
                        count_nxt_s = count_r + ONE;
                    end
                end
                S_IDLE, S_RUN: begin
                    data_nxt_s = step_s;
                    if (step_s == start_r) begin
                        wrap_nxt_s   = 1'b1;
                        period_nxt_s = count_r + ONE;
                        count_nxt_s  = ZERO;
                    end else begin
                        count_nxt_s = count_r + ONE;
                    end
                    if (step_s == LOCKUP) begin
                        state_nxt_s = S_LOCK;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
                default: begin
                    data_nxt_s  = SEED;
                    start_nxt_s = SEED;
                    count_nxt_s = ZERO;
                    state_nxt_s = RST_STATE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r  <= RST_STATE;
            data_r   <= SEED;
            start_r  <= SEED;
            count_r  <= ZERO;
            period_r <= ZERO;
            wrap_r   <= 1'b0;
            locked_r <= (RST_STATE == S_LOCK);
        end else begin
            state_r  <= state_nxt_s;
            data_r   <= data_nxt_s;
            start_r  <= start_nxt_s;
            count_r  <= count_nxt_s;
            period_r <= period_nxt_s;
            wrap_r   <= wrap_nxt_s;
            locked_r <= (state_nxt_s == S_LOCK);
        end
    end

    assign o_data   = data_r;
    assign o_wrap   = wrap_r;
    assign o_count  = count_r;
    assign o_period = period_r;
    assign o_locked = locked_r;

endmodule
